serial_read_buffer: RTL and testbench

Receive-side counterpart of the serial write buffer: captures n bits from a synchronous serial line into a left-aligned parallel register, one bit per read strobe, MSB first. Sits downstream of the bus-line synchronizer/edge detector, which supplies the already-synchronized line and the read strobe. Its parallel output is consumed by the MITM control logic, and can be handed unchanged to the serial write buffer for forwarding.

---
 rtl/serial_read_buffer_pkg.sv | 16 +
 rtl/serial_read_buffer.sv | 83 ++++++++
 tb/tb_serial_read_buffer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/serial_read_buffer_pkg.sv
// Shared definitions for the serial read/write buffers: FSM state encodings
// and the width helper for bit-count ports.
package serial_read_buffer_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_IDLE  = 2'b01,
        ST_READ  = 2'b10
    } state_t;

    // Width needed to hold any count from 0 to n inclusive.
    function automatic int ctr_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_read_buffer.sv
// Captures up to BUF_SIZE bits from a synchronized serial line, MSB first,
// into a left-aligned parallel register, one bit per read strobe.
module serial_read_buffer
    import serial_read_buffer_pkg::*;
#(
    parameter int  BUF_SIZE = 8,
    localparam int CTR_SIZE = ctr_width(BUF_SIZE)
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                read_sig,
    input  logic                data_in,
    input  logic [CTR_SIZE-1:0] read_count,
    output logic [BUF_SIZE-1:0] data_out,
    output logic [CTR_SIZE-1:0] bits_read,
    output logic                done_sig
);

    localparam int                PTR_W    = $clog2(BUF_SIZE);
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(BUF_SIZE - 1);
    localparam logic [CTR_SIZE-1:0] BUF_MAX = CTR_SIZE'(BUF_SIZE);

    state_t              state;
    logic [PTR_W-1:0]    pointer;
    logic [CTR_SIZE-1:0] remaining;
    logic [CTR_SIZE-1:0] clamped_count;

    assign clamped_count = (read_count > BUF_MAX) ? BUF_MAX : read_count;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            data_out  <= '0;
            bits_read <= '0;
            done_sig  <= 1'b0;
            pointer   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    data_out  <= '0;
                    bits_read <= '0;
                    pointer   <= '0;
                    remaining <= '0;
                    done_sig  <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (start) begin
                        data_out  <= '0;
                        bits_read <= '0;
                        pointer   <= PTR_MAX;
                        remaining <= clamped_count;
                        if (read_count != '0) begin
                            done_sig <= 1'b0;
                            state    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    // A strobe coincident with stop still lands before the abort.
                    if (read_sig) begin
                        data_out[pointer] <= data_in;
                        bits_read         <= bits_read + CTR_SIZE'(1);
                        remaining         <= remaining - CTR_SIZE'(1);
                        pointer           <= pointer - PTR_W'(1);
                    end
                    if ((read_sig && remaining == CTR_SIZE'(1)) || stop) begin
                        done_sig <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    done_sig <= 1'b0;
                    state    <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_read_buffer.sv
// Directed, table-driven bench for serial_read_buffer with BUF_SIZE = 8.
module tb_serial_read_buffer;

    localparam int BUF_SIZE = 8;
    localparam int CTR_SIZE = 4;

    logic                sys_clk = 1'b0;
    logic                rst_n   = 1'b0;
    logic                start   = 1'b0;
    logic                stop    = 1'b0;
    logic                read_sig = 1'b0;
    logic                data_in = 1'b0;
    logic [CTR_SIZE-1:0] read_count = '0;
    logic [BUF_SIZE-1:0] data_out;
    logic [CTR_SIZE-1:0] bits_read;
    logic                done_sig;

    int check_count = 0;
    int fail_count  = 0;

    typedef struct {
        string               name;
        logic [CTR_SIZE-1:0] rc;
        int                  n_strobes;
        logic [15:0]         bits;
        int                  stop_at;
        logic [BUF_SIZE-1:0] exp_data;
        logic [CTR_SIZE-1:0] exp_bits;
    } vec_t;

    serial_read_buffer #(.BUF_SIZE(BUF_SIZE)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .read_sig   (read_sig),
        .data_in    (data_in),
        .read_count (read_count),
        .data_out   (data_out),
        .bits_read  (bits_read),
        .done_sig   (done_sig)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_value(input string name, input int actual, input int expected);
        check_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic check_output(input string name, input logic [BUF_SIZE-1:0] exp_data,
                                input logic [CTR_SIZE-1:0] exp_bits, input logic exp_done);
        check_value({name, ".data_out"}, int'(data_out), int'(exp_data));
        check_value({name, ".bits_read"}, int'(bits_read), int'(exp_bits));
        check_value({name, ".done_sig"}, int'(done_sig), int'(exp_done));
    endtask

    // Runs one transfer and tracks done/bits_read per strobe with a tiny model.
    task automatic apply_stimulus(input vec_t v);
        int   clamp;
        int   captured;
        logic reading;
        clamp = (int'(v.rc) > BUF_SIZE) ? BUF_SIZE : int'(v.rc);
        start      = 1'b1;
        read_count = v.rc;
        tick();
        start = 1'b0;
        reading = (v.rc != 0);
        captured = 0;
        check_output({v.name, ".start"}, '0, '0, !reading);
        for (int i = 0; i < v.n_strobes; i++) begin
            read_sig = 1'b1;
            data_in  = v.bits[15-i];
            stop     = (i == v.stop_at);
            tick();
            read_sig = 1'b0;
            stop     = 1'b0;
            if (reading) begin
                captured++;
                if (captured == clamp || i == v.stop_at) reading = 1'b0;
            end
            check_value({v.name, ".strobe_done"}, int'(done_sig), int'(!reading));
            check_value({v.name, ".strobe_count"}, int'(bits_read), captured);
        end
        check_value({v.name, ".final_data"}, int'(data_out), int'(v.exp_data));
        check_value({v.name, ".final_bits"}, int'(bits_read), int'(v.exp_bits));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"full",    4'd8,  8,  16'hB200, -1, 8'hB2, 4'd8};
        vecs[1] = '{"partial", 4'd3,  5,  16'hD800, -1, 8'hC0, 4'd3};
        vecs[2] = '{"clamp",   4'd12, 10, 16'hABC0, -1, 8'hAB, 4'd8};
        vecs[3] = '{"abort",   4'd8,  5,  16'hF800,  4, 8'hF8, 4'd5};
        vecs[4] = '{"zero",    4'd0,  2,  16'hC000, -1, 8'h00, 4'd0};
        vecs[5] = '{"single",  4'd1,  1,  16'h8000, -1, 8'h80, 4'd1};

        // Reset held low for three cycles, then released between edges.
        rst_n = 1'b0;
        repeat (3) tick();
        check_output("reset_low", '0, '0, 1'b0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        #1;
        check_value("reset_release.done_sig", int'(done_sig), 0);
        tick();
        check_output("reset_first_edge", '0, '0, 1'b1);

        for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

        // Asynchronous reset after 2 of 6 bits discards the partial transfer.
        start = 1'b1;
        read_count = 4'd6;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            read_sig = 1'b1;
            data_in  = 1'b1;
            tick();
        end
        read_sig = 1'b0;
        check_output("midreset_before", 8'hC0, 4'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("midreset_async", '0, '0, 1'b0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        tick();
        check_output("midreset_release", '0, '0, 1'b1);
        apply_stimulus('{"after_reset", 4'd6, 6, 16'hCC00, -1, 8'hCC, 4'd6});

        // A strobe coincident with start must not be captured.
        start      = 1'b1;
        read_count = 4'd2;
        read_sig   = 1'b1;
        data_in    = 1'b1;
        tick();
        start = 1'b0;
        check_output("coincident_start", '0, '0, 1'b0);
        data_in = 1'b0;
        tick();
        data_in = 1'b1;
        tick();
        read_sig = 1'b0;
        check_output("coincident_done", 8'h40, 4'd2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
